// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle main control FSM (IF/ID/EXE/MEM/WB)
//
// Sequences each instruction through fetch, decode, execute, memory and
// write-back states. It drives the datapath write enables and mux selects,
// and sends ealuc straight to the ALU. It also handles the memory ready
// handshake and counts retired instructions.
//
// Ports:
//   clk, clrn             clock; synchronous active-low reset
//   op, func              IR[31:26] and IR[5:0]
//   zero                  ALU result == 0 (valid in EXE)
//   mem_rdy               memory has completed the current request
//   mem_req, wmem, iord   memory request, write strobe, address select
//   wir, wpc, wreg        IR, PC and register-file load enables
//   regdst, memtoreg      register-file destination and write-data selects
//   sext                  sign-extend (1) or zero-extend (0) imm16
//   alusrca, alusrcb      ALU operand selects
//   pcsrc                 PC source select
//   ealuc                 ALU operation
//   state                 current state code (IF=0 ID=1 EXE=2 MEM=3 WB=4)
//   illegal               one-cycle pulse in ID for an undecodable instruction
//   instret               retired-instruction count (wraps)

module mc_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             wmem,
    output logic             iord,
    output logic             wir,
    output logic             wpc,
    output logic             wreg,
    output logic             regdst,
    output logic             memtoreg,
    output logic             sext,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [3:0]       ealuc,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b1001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    // Instruction decode
    logic       is_r, is_imm, is_lw, is_sw, is_br, is_j, is_legal;
    logic       r_ok;
    logic [3:0] r_alu, i_alu;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (func)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            default:   r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        case (op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_XORI: i_alu = ALU_XOR;
            default: i_alu = ALU_ADD;
        endcase
    end

    assign is_r     = (op == OP_RTYPE) && r_ok;
    assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_br    = (op == OP_BEQ) || (op == OP_BNE);
    assign is_j     = (op == OP_J);
    assign is_legal = is_r || is_imm || is_lw || is_sw || is_br || is_j;

    // Outputs and next state
    always_comb begin
        mem_req  = 1'b0;
        wmem     = 1'b0;
        iord     = 1'b0;
        wir      = 1'b0;
        wpc      = 1'b0;
        wreg     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        ealuc    = ALU_ADD;
        illegal  = 1'b0;
        retire   = 1'b0;
        state_d  = state_q;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_rdy) begin
                    wir     = 1'b1;
                    wpc     = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // Branch target precomputed into ALUOut while decoding
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (is_j) begin
                    wpc     = 1'b1;
                    pcsrc   = 2'b11;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (is_r) begin
                    ealuc   = r_alu;
                    state_d = S_WB;
                end else if (is_imm) begin
                    alusrcb = 2'b10;
                    ealuc   = i_alu;
                    sext    = (op == OP_ADDI);
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alusrcb = 2'b10;
                    sext    = 1'b1;
                    state_d = S_MEM;
                end else if (is_br) begin
                    ealuc   = ALU_SUB;
                    pcsrc   = 2'b01;
                    wpc     = (op == OP_BEQ) ? zero : ~zero;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else begin
                    // Opcode changed under us; abandon the instruction
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = is_sw;
                if (mem_rdy) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        retire  = is_sw;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                wreg     = 1'b1;
                regdst   = is_r;
                memtoreg = is_lw;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset must not leak any write or request to the datapath
        if (!clrn) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wreg    = 1'b0;
            wmem    = 1'b0;
            mem_req = 1'b0;
            illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit
module tb_mc_control_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic [5:0]    op, func;
    logic          zero, mem_rdy;
    logic          mem_req, wmem, iord, wir, wpc, wreg, regdst, memtoreg, sext, alusrca;
    logic [1:0]    alusrcb, pcsrc;
    logic [3:0]    ealuc;
    logic [2:0]    state;
    logic          illegal;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    mc_control_unit #(.CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .wmem(wmem), .iord(iord), .wir(wir), .wpc(wpc), .wreg(wreg),
        .regdst(regdst), .memtoreg(memtoreg), .sext(sext), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .ealuc(ealuc), .state(state),
        .illegal(illegal), .instret(instret)
    );

    logic [18:0] dut_vec;
    assign dut_vec = {mem_req, wmem, iord, wir, wpc, wreg, regdst, memtoreg, sext, alusrca,
                      alusrcb, pcsrc, ealuc, illegal};

    int checks = 0;
    int errors = 0;
    int ref_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction classes
    localparam int C_ILL = 0, C_R = 1, C_IMM = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_BNE = 6, C_J = 7;

    function automatic int cls_of(logic [5:0] o, logic [5:0] f);
        case (o)
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b100110) ? C_R : C_ILL;
            6'b001000, 6'b001100, 6'b001101, 6'b001110: return C_IMM;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] op_alu(int c, logic [5:0] o, logic [5:0] f);
        if (c == C_R) begin
            if (f == 6'b100010) return 4'b0110;
            if (f == 6'b100100) return 4'b0000;
            if (f == 6'b100101) return 4'b0001;
            if (f == 6'b100110) return 4'b1001;
            return 4'b0010;
        end
        if (c == C_IMM) begin
            if (o == 6'b001100) return 4'b0000;
            if (o == 6'b001101) return 4'b0001;
            if (o == 6'b001110) return 4'b1001;
            return 4'b0010;
        end
        if (c == C_BEQ || c == C_BNE) return 4'b0110;
        return 4'b0010;
    endfunction

    // Expected outputs for a given phase of an instruction, from the control table
    function automatic logic [18:0] exp_out(int stg, int c, logic [5:0] o, logic [5:0] f,
                                            logic z, logic rdy);
        logic mr = 0, wm = 0, io = 0, wi = 0, wp = 0, wr = 0, rd = 0, mt = 0, se = 0, sa = 0, il = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [3:0] al = 4'b0010;
        case (stg)
            0: begin mr = 1; sb = 2'b01; wi = rdy; wp = rdy; end
            1: begin
                sb = 2'b11; se = 1;
                if (c == C_J) begin wp = 1; ps = 2'b11; end
                if (c == C_ILL) il = 1;
            end
            2: begin
                sa = 1; al = op_alu(c, o, f);
                if (c == C_IMM) begin sb = 2'b10; se = (o == 6'b001000); end
                if (c == C_LW || c == C_SW) begin sb = 2'b10; se = 1; end
                if (c == C_BEQ) begin ps = 2'b01; wp = z; end
                if (c == C_BNE) begin ps = 2'b01; wp = ~z; end
            end
            3: begin mr = 1; io = 1; wm = (c == C_SW); end
            4: begin wr = 1; rd = (c == C_R); mt = (c == C_LW); end
            default: ;
        endcase
        return {mr, wm, io, wi, wp, wr, rd, mt, se, sa, sb, ps, al, il};
    endfunction

    // Drives one instruction through its expected phase path, checking every cycle.
    // Entered and left at a falling edge with the DUT in IF.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int if_st, input int mem_st);
        int c;
        int path[$];
        c = cls_of(o, f);
        path = {0, 1};
        if (c == C_R || c == C_IMM) begin path.push_back(2); path.push_back(4); end
        if (c == C_LW) begin path.push_back(2); path.push_back(3); path.push_back(4); end
        if (c == C_SW) begin path.push_back(2); path.push_back(3); end
        if (c == C_BEQ || c == C_BNE) path.push_back(2);
        chk("instret_before", 32'(instret), 32'(ref_cnt % (1 << CW)));
        foreach (path[k]) begin
            int reps;
            reps = (path[k] == 0) ? if_st + 1 : (path[k] == 3) ? mem_st + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                op = o; func = f; zero = 1'($urandom);
                mem_rdy = (path[k] == 0 || path[k] == 3) ? (r == reps - 1) : 1'($urandom);
                #1;
                chk($sformatf("state op=%b f=%b", o, f), 32'(state), 32'(path[k]));
                chk($sformatf("outs op=%b f=%b st=%0d", o, f, path[k]), 32'(dut_vec),
                    32'(exp_out(path[k], c, o, f, zero, mem_rdy)));
                @(negedge clk);
            end
        end
        if (c != C_ILL) ref_cnt++;
        chk("state_after", 32'(state), 32'd0);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        int         cyc;
        int         ret;
        logic [3:0] alu;
        logic       wexe;
        int         ill;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int cnt, ill_cnt;
        logic [3:0] cap_alu;
        logic cap_wpc;
        logic [CW-1:0] start;

        tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 4'b0010, 1'b0, 0};
        tbl[1]  = '{6'b000000, 6'b100010, 1'b0, 4, 1, 4'b0110, 1'b0, 0};
        tbl[2]  = '{6'b000000, 6'b100100, 1'b0, 4, 1, 4'b0000, 1'b0, 0};
        tbl[3]  = '{6'b000000, 6'b100101, 1'b0, 4, 1, 4'b0001, 1'b0, 0};
        tbl[4]  = '{6'b000000, 6'b100110, 1'b0, 4, 1, 4'b1001, 1'b0, 0};
        tbl[5]  = '{6'b000000, 6'b000000, 1'b0, 2, 0, 4'b0010, 1'b0, 1};
        tbl[6]  = '{6'b001000, 6'b000000, 1'b0, 4, 1, 4'b0010, 1'b0, 0};
        tbl[7]  = '{6'b001100, 6'b000000, 1'b0, 4, 1, 4'b0000, 1'b0, 0};
        tbl[8]  = '{6'b001101, 6'b000000, 1'b0, 4, 1, 4'b0001, 1'b0, 0};
        tbl[9]  = '{6'b001110, 6'b000000, 1'b0, 4, 1, 4'b1001, 1'b0, 0};
        tbl[10] = '{6'b100011, 6'b000000, 1'b0, 5, 1, 4'b0010, 1'b0, 0};
        tbl[11] = '{6'b101011, 6'b000000, 1'b0, 4, 1, 4'b0010, 1'b0, 0};
        tbl[12] = '{6'b000100, 6'b000000, 1'b1, 3, 1, 4'b0110, 1'b1, 0};
        tbl[13] = '{6'b000101, 6'b000000, 1'b1, 3, 1, 4'b0110, 1'b0, 0};
        tbl[14] = '{6'b000010, 6'b000000, 1'b0, 2, 1, 4'b0010, 1'b0, 0};
        tbl[15] = '{6'b111111, 6'b000000, 1'b0, 2, 0, 4'b0010, 1'b0, 1};

        clrn = 1'b0; op = '0; func = '0; zero = 1'b0; mem_rdy = 1'b1;

        // Reset state, with strobes forced low even though IF sees mem_rdy
        @(negedge clk); #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wir", 32'(wir), 32'd0);
        chk("rst_wpc", 32'(wpc), 32'd0);
        mem_rdy = 1'b0; clrn = 1'b1;
        @(negedge clk);

        // Table: cycle count, retirement, EXE ALU op, EXE wpc, illegal pulses
        foreach (tbl[i]) begin
            op = tbl[i].op; func = tbl[i].func; zero = tbl[i].zero; mem_rdy = 1'b1;
            start = instret; cnt = 0; ill_cnt = 0; cap_alu = 4'b0010; cap_wpc = 1'b0;
            do begin
                #1;
                if (state == 3'd2) begin cap_alu = ealuc; cap_wpc = wpc; end
                if (illegal) ill_cnt++;
                @(negedge clk);
                cnt++;
            end while (state != 3'd0 && cnt < 20);
            chk($sformatf("tbl%0d_cycles", i), 32'(cnt), 32'(tbl[i].cyc));
            chk($sformatf("tbl%0d_retire", i), 32'(CW'(instret - start)), 32'(tbl[i].ret));
            chk($sformatf("tbl%0d_exe_alu", i), 32'(cap_alu), 32'(tbl[i].alu));
            chk($sformatf("tbl%0d_exe_wpc", i), 32'(cap_wpc), 32'(tbl[i].wexe));
            chk($sformatf("tbl%0d_illegal", i), 32'(ill_cnt), 32'(tbl[i].ill));
            ref_cnt += tbl[i].ret;
        end

        // lw stalled three cycles in MEM, add stalled in IF
        run_instr(6'b100011, 6'b000000, 0, 3);
        run_instr(6'b000000, 6'b100000, 2, 0);

        // Reset during a stalled sw in MEM
        op = 6'b101011; func = '0; mem_rdy = 1'b1; cnt = 0;
        while (state != 3'd3 && cnt < 10) begin
            @(negedge clk);
            if (state == 3'd3) mem_rdy = 1'b0;
            cnt++;
        end
        chk("sw_reach_mem", 32'(state), 32'd3);
        mem_rdy = 1'b0; #1;
        chk("sw_wmem_before_rst", 32'(wmem), 32'd1);
        clrn = 1'b0; #1;
        chk("sw_wmem_in_rst", 32'(wmem), 32'd0);
        chk("sw_mem_req_in_rst", 32'(mem_req), 32'd0);
        @(negedge clk); #1;
        chk("sw_rst_state", 32'(state), 32'd0);
        chk("sw_rst_instret", 32'(instret), 32'd0);
        clrn = 1'b1; ref_cnt = 0;
        @(negedge clk);
        chk("post_rst_idle", 32'(state), 32'd0);
        run_instr(6'b000000, 6'b100000, 0, 0);

        // Randomized instruction stream; instret wraps several times
        for (int n = 0; n < 80; n++) begin
            logic [5:0] ro, rf;
            int pick;
            pick = $urandom_range(0, 15);
            rf = 6'($urandom);
            case (pick)
                0, 1, 2: begin ro = 6'b000000; rf = 6'(32 + 2 * $urandom_range(0, 3)); end
                3:  begin ro = 6'b000000; rf = 6'b100110; end
                4:  ro = 6'b001000;
                5:  ro = 6'b001100;
                6:  ro = 6'b001101;
                7:  ro = 6'b001110;
                8, 9: ro = 6'b100011;
                10: ro = 6'b101011;
                11: ro = 6'b000100;
                12: ro = 6'b000101;
                13: ro = 6'b000010;
                default: ro = 6'($urandom);
            endcase
            run_instr(ro, rf, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        chk("final_instret", 32'(instret), 32'(ref_cnt % (1 << CW)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
